// File: rtl/microcode_pkg.sv
// Shared definitions for the microcoded control sequencer and its datapath:
// control-word layout, sequencer states, o_ctrl field map and reference opcodes.
package microcode_pkg;

    // Sequencer bits at the bottom of every control-store word
    localparam int unsigned CW_END      = 0;
    localparam int unsigned CW_HALT     = 1;
    localparam int unsigned CW_IMM_OE   = 2;
    localparam int unsigned CW_CTRL_LSB = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } seq_state_t;

    // o_ctrl field indices as seen by the datapath
    localparam int unsigned ALU_OE   = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned REG_A_IN = 2;
    localparam int unsigned REG_A_OE = 3;
    localparam int unsigned REG_B_IN = 4;
    localparam int unsigned RAM_IN   = 5;
    localparam int unsigned RAM_OE   = 6;
    localparam int unsigned MAR_IN   = 7;
    localparam int unsigned INSTR_IN = 8;
    localparam int unsigned PC_IN    = 9;
    localparam int unsigned PC_OE    = 10;
    localparam int unsigned OUT_IN   = 11;
    localparam int unsigned INCR_PC  = 12;

    // Opcodes with dedicated routines in the reference microprogram
    localparam logic [7:0] OP_HALT    = 8'h01;
    localparam logic [7:0] OP_STORE   = 8'h03;
    localparam logic [7:0] OP_IMM     = 8'h2A;
    localparam logic [7:0] OP_RUNAWAY = 8'hFF;

endpackage

// File: rtl/control_store.sv
// Asynchronous-read control store addressed by {flagZ, flagN, instr, step}.
// Holds the reference microprogram; named images are bound by the ROM macro.
module control_store
    import microcode_pkg::*;
#(
    parameter string       INIT_FILE   = "",
    parameter int unsigned STEP_W      = 3,
    parameter int unsigned FETCH_STEPS = 3,
    parameter int unsigned ADDR_W      = 2 + 8 + STEP_W,
    parameter int unsigned DATA_W      = 16
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

    localparam int unsigned INSTR_W = ADDR_W - 2 - STEP_W;

    if (INIT_FILE != "") begin : g_noImageModel
        $error("control_store: only the reference microprogram is modelled in RTL");
    end

    function automatic logic [DATA_W-1:0] builtinWord(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0]  word;
        logic [STEP_W-1:0]  step;
        logic [STEP_W-1:0]  execStep;
        logic [INSTR_W-1:0] instr;
        logic               flagN;
        logic               flagZ;
        word     = '0;
        step     = addr[STEP_W-1:0];
        instr    = addr[STEP_W +: INSTR_W];
        flagN    = addr[STEP_W + INSTR_W];
        flagZ    = addr[STEP_W + INSTR_W + 1];
        execStep = step - STEP_W'(FETCH_STEPS);
        if (step < STEP_W'(FETCH_STEPS)) begin
            if (step == '0) begin
                word[CW_CTRL_LSB + PC_OE]  = 1'b1;
                word[CW_CTRL_LSB + MAR_IN] = 1'b1;
            end else if (step == STEP_W'(FETCH_STEPS - 1)) begin
                word[CW_CTRL_LSB + RAM_OE]   = 1'b1;
                word[CW_CTRL_LSB + INSTR_IN] = 1'b1;
            end else begin
                word[CW_CTRL_LSB + RAM_OE]  = 1'b1;
                word[CW_CTRL_LSB + INCR_PC] = 1'b1;
            end
            // Stray sequencer bits in fetch rows; the sequencer must ignore them
            if (instr == INSTR_W'(OP_STORE)) begin
                word[CW_END]  = 1'b1;
                word[CW_HALT] = 1'b1;
            end
        end else if (instr == INSTR_W'(OP_IMM)) begin
            word[CW_END] = 1'b1;
            if (execStep == '0) begin
                word[CW_IMM_OE]              = 1'b1;
                word[CW_CTRL_LSB + REG_A_IN] = 1'b1;
            end
        end else if (instr == INSTR_W'(OP_HALT)) begin
            if (execStep == '0) begin
                word[CW_HALT]              = 1'b1;
                word[CW_CTRL_LSB + OUT_IN] = 1'b1;
            end else begin
                word[CW_END] = 1'b1;
            end
        end else if (instr == INSTR_W'(OP_RUNAWAY)) begin
            // Never ends; flag-dependent bits expose the latched flags
            word[CW_CTRL_LSB + ALU_OE]   = 1'b1;
            word[CW_CTRL_LSB + ALU_SUB]  = flagZ;
            word[CW_CTRL_LSB + REG_A_OE] = flagN;
            word[CW_CTRL_LSB + OUT_IN]   = step[0];
        end else if (instr == INSTR_W'(OP_STORE)) begin
            if (execStep == '0) begin
                word[CW_CTRL_LSB + RAM_IN] = 1'b1;
                word[CW_CTRL_LSB + MAR_IN] = 1'b1;
            end else begin
                word[CW_END]                 = 1'b1;
                word[CW_CTRL_LSB + REG_B_IN] = 1'b1;
            end
        end else begin
            if (execStep == '0) begin
                word[CW_CTRL_LSB + REG_A_OE] = 1'b1;
                word[CW_CTRL_LSB + OUT_IN]   = 1'b1;
            end else begin
                word[CW_END]                 = 1'b1;
                word[CW_CTRL_LSB + REG_B_IN] = 1'b1;
            end
        end
        return word;
    endfunction

    assign o_data = builtinWord(i_addr);

endmodule

// File: rtl/microcode_sequencer.sv
// Microcoded control sequencer: fetch, variable-length execute via END,
// wait-state stalling, halt/resume, flag latching and a runaway-step watchdog.
module microcode_sequencer
    import microcode_pkg::*;
#(
    parameter int unsigned INSTR_W     = 8,
    parameter int unsigned STEP_W      = 3,
    parameter int unsigned FETCH_STEPS = 3,
    parameter int unsigned CTRL_W      = 16,
    parameter int unsigned IMM_HI      = 5,
    parameter int unsigned IMM_BITS    = 3,
    parameter int unsigned IMM_W       = 8,
    parameter string       INIT_FILE   = ""
) (
    input  logic                i_clk,
    input  logic                i_nReset,
    input  logic [INSTR_W-1:0]  i_instruction,
    input  logic                i_aluFlagN,
    input  logic                i_aluFlagZ,
    input  logic                i_wait,
    input  logic                i_resume,
    output logic [CTRL_W-4:0]   o_ctrl,
    output logic [IMM_W-1:0]    o_immediate,
    output logic                o_immediateOe,
    output logic                o_ramReadDataSelect,
    output logic                o_pcOe,
    output logic                o_halted,
    output logic                o_seqError
);

    localparam int unsigned       ADDR_W     = 2 + INSTR_W + STEP_W;
    localparam int unsigned       MAX_STEPS  = 2 ** STEP_W;
    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(MAX_STEPS - 1);
    localparam logic [STEP_W-1:0] LATCH_STEP = STEP_W'(FETCH_STEPS - 1);
    localparam logic [STEP_W-1:0] EXEC_STEP  = STEP_W'(FETCH_STEPS);

    seq_state_t         r_state;
    seq_state_t         nextState;
    logic [STEP_W-1:0]  r_step;
    logic [STEP_W-1:0]  nextStep;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] nextInstr;
    logic               r_flagN;
    logic               nextFlagN;
    logic               r_flagZ;
    logic               nextFlagZ;
    logic               r_seqError;
    logic               nextSeqError;
    logic [CTRL_W-1:0]  ctrlWord;
    logic               running;
    logic               inExec;
    logic               haltStep;
    logic               endStep;

    control_store #(
        .INIT_FILE   (INIT_FILE),
        .STEP_W      (STEP_W),
        .FETCH_STEPS (FETCH_STEPS),
        .ADDR_W      (ADDR_W),
        .DATA_W      (CTRL_W)
    ) u_controlStore (
        .i_addr ({r_flagZ, r_flagN, r_instr, r_step}),
        .o_data (ctrlWord)
    );

    // END/HALT only count once the fetch steps are done; HALT implies END
    assign running  = (r_state == RUN);
    assign inExec   = (r_step >= EXEC_STEP);
    assign haltStep = inExec && ctrlWord[CW_HALT];
    assign endStep  = inExec && (ctrlWord[CW_END] || ctrlWord[CW_HALT]);

    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            r_state    <= IDLE;
            r_step     <= '0;
            r_instr    <= '0;
            r_flagN    <= 1'b0;
            r_flagZ    <= 1'b0;
            r_seqError <= 1'b0;
        end else begin
            r_state    <= nextState;
            r_step     <= nextStep;
            r_instr    <= nextInstr;
            r_flagN    <= nextFlagN;
            r_flagZ    <= nextFlagZ;
            r_seqError <= nextSeqError;
        end
    end

    always_comb begin
        nextState    = r_state;
        nextStep     = r_step;
        nextInstr    = r_instr;
        nextFlagN    = r_flagN;
        nextFlagZ    = r_flagZ;
        nextSeqError = 1'b0;
        unique case (r_state)
            IDLE: nextState = RUN;
            RUN: begin
                if (!i_wait) begin
                    nextStep = r_step + STEP_W'(1);
                    if (r_step == LATCH_STEP) begin
                        nextInstr = i_instruction;
                        nextFlagN = i_aluFlagN;
                        nextFlagZ = i_aluFlagZ;
                    end
                    if (haltStep) begin
                        nextState = HALT;
                        nextStep  = '0;
                    end else if (endStep) begin
                        nextStep = '0;
                    end else if (r_step == LAST_STEP) begin
                        nextStep     = '0;
                        nextSeqError = 1'b1;
                    end
                end
            end
            HALT: begin
                nextStep = '0;
                if (i_resume) begin
                    nextState = RUN;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Datapath strobes are only live while running
    assign o_ctrl              = running ? ctrlWord[CTRL_W-1:CW_CTRL_LSB] : '0;
    assign o_immediateOe       = running && ctrlWord[CW_IMM_OE];
    assign o_pcOe              = running && (r_step == '0);
    assign o_ramReadDataSelect = running && (r_step < LATCH_STEP);
    assign o_halted            = (r_state == HALT);
    assign o_seqError          = r_seqError;
    assign o_immediate         = IMM_W'(r_instr[IMM_HI -: IMM_BITS]);

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: a cycle table walking several
// instructions plus hand-written async-reset sequences.
module tb_microcode_sequencer;

    logic        i_clk = 1'b0;
    logic        i_nReset = 1'b1;
    logic [7:0]  i_instruction = 8'h00;
    logic        i_aluFlagN = 1'b0;
    logic        i_aluFlagZ = 1'b0;
    logic        i_wait = 1'b0;
    logic        i_resume = 1'b0;
    logic [12:0] o_ctrl;
    logic [7:0]  o_immediate;
    logic        o_immediateOe;
    logic        o_ramReadDataSelect;
    logic        o_pcOe;
    logic        o_halted;
    logic        o_seqError;

    int tests = 0;
    int fails = 0;

    microcode_sequencer dut (
        .i_clk               (i_clk),
        .i_nReset            (i_nReset),
        .i_instruction       (i_instruction),
        .i_aluFlagN          (i_aluFlagN),
        .i_aluFlagZ          (i_aluFlagZ),
        .i_wait              (i_wait),
        .i_resume            (i_resume),
        .o_ctrl              (o_ctrl),
        .o_immediate         (o_immediate),
        .o_immediateOe       (o_immediateOe),
        .o_ramReadDataSelect (o_ramReadDataSelect),
        .o_pcOe              (o_pcOe),
        .o_halted            (o_halted),
        .o_seqError          (o_seqError)
    );

    always #5 i_clk = ~i_clk;

    // Expected o_ctrl words of the reference microprogram
    localparam logic [12:0] F0   = 13'h0480; // PC_OE | MAR_IN
    localparam logic [12:0] F1   = 13'h1040; // RAM_OE | INCR_PC
    localparam logic [12:0] F2   = 13'h0140; // RAM_OE | INSTR_IN
    localparam logic [12:0] DEF3 = 13'h0808; // REG_A_OE | OUT_IN
    localparam logic [12:0] ENDW = 13'h0010; // REG_B_IN
    localparam logic [12:0] IMM3 = 13'h0004; // REG_A_IN
    localparam logic [12:0] ST3  = 13'h00A0; // RAM_IN | MAR_IN
    localparam logic [12:0] HLT3 = 13'h0800; // OUT_IN

    typedef struct {
        logic        stall;
        logic        resume;
        logic [7:0]  instr;
        logic        flagN;
        logic        flagZ;
        logic [12:0] ctrl;
        logic        pcOe;
        logic        ramSel;
        logic        immOe;
        logic [7:0]  imm;
        logic        halted;
        logic        seqErr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic stall, input logic resume, input logic [7:0] instr,
                                input logic flagN, input logic flagZ, input logic [12:0] ctrl,
                                input logic pcOe, input logic ramSel, input logic immOe,
                                input logic [7:0] imm, input logic halted, input logic seqErr);
        vec_t v;
        v.stall = stall;   v.resume = resume; v.instr = instr;
        v.flagN = flagN;   v.flagZ = flagZ;   v.ctrl = ctrl;
        v.pcOe = pcOe;     v.ramSel = ramSel; v.immOe = immOe;
        v.imm = imm;       v.halted = halted; v.seqErr = seqErr;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, got, exp);
        end
    endtask

    task automatic checkAll(input int idx, input logic [12:0] ctrl, input logic pcOe, input logic ramSel,
                            input logic immOe, input logic [7:0] imm, input logic halted, input logic seqErr);
        check("ctrl", idx, 32'(o_ctrl), 32'(ctrl));
        check("pcOe", idx, 32'(o_pcOe), 32'(pcOe));
        check("ramSel", idx, 32'(o_ramReadDataSelect), 32'(ramSel));
        check("immOe", idx, 32'(o_immediateOe), 32'(immOe));
        check("imm", idx, 32'(o_immediate), 32'(imm));
        check("halted", idx, 32'(o_halted), 32'(halted));
        check("seqErr", idx, 32'(o_seqError), 32'(seqErr));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // stall resume instr  N  Z   ctrl  pc ram immOe imm halted err
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 13'h0, 0, 0, 0, 8'd0, 0, 0)); // 0 IDLE
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, F0,    1, 1, 0, 8'd0, 0, 0)); // 1 s0
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, F1,    0, 1, 0, 8'd0, 0, 0)); // 2 s1
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, F2,    0, 0, 0, 8'd0, 0, 0)); // 3 s2 latch 00
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, DEF3,  0, 0, 0, 8'd0, 0, 0)); // 4 s3
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, ENDW,  0, 0, 0, 8'd0, 0, 0)); // 5 s4 END
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, F0,    1, 1, 0, 8'd0, 0, 0)); // 6 s0
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, F1,    0, 1, 0, 8'd0, 0, 0)); // 7 s1
        vecs.push_back(mk(0, 0, 8'h2A, 1, 0, F2,    0, 0, 0, 8'd0, 0, 0)); // 8 s2 latch 2A
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, IMM3,  0, 0, 1, 8'd5, 0, 0)); // 9 s3 IMM END
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, F0,    1, 1, 0, 8'd5, 0, 0)); // 10 s0
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, F1,    0, 1, 0, 8'd5, 0, 0)); // 11 s1
        vecs.push_back(mk(0, 0, 8'h03, 0, 0, F2,    0, 0, 0, 8'd5, 0, 0)); // 12 s2 latch 03
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, ST3,   0, 0, 0, 8'd0, 0, 0)); // 13 s3 stall
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, ST3,   0, 0, 0, 8'd0, 0, 0)); // 14 s3 stall
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, ST3,   0, 0, 0, 8'd0, 0, 0)); // 15 s3 stall
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, ST3,   0, 0, 0, 8'd0, 0, 0)); // 16 s3 go
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, ENDW,  0, 0, 0, 8'd0, 0, 0)); // 17 s4 END
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, F0,    1, 1, 0, 8'd0, 0, 0)); // 18 s0 stray END/HALT
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, F1,    0, 1, 0, 8'd0, 0, 0)); // 19 s1 stray END/HALT
        vecs.push_back(mk(0, 0, 8'h01, 0, 0, F2,    0, 0, 0, 8'd0, 0, 0)); // 20 s2 latch 01
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, HLT3,  0, 0, 0, 8'd0, 0, 0)); // 21 s3 HALT word
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 13'h0, 0, 0, 0, 8'd0, 1, 0)); // 22 HALT, wait ignored
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 13'h0, 0, 0, 0, 8'd0, 1, 0)); // 23 HALT
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 13'h0, 0, 0, 0, 8'd0, 1, 0)); // 24 HALT resume
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, F0,    1, 1, 0, 8'd0, 0, 0)); // 25 s0, resume ignored
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, F1,    0, 1, 0, 8'd0, 0, 0)); // 26 s1
        vecs.push_back(mk(0, 0, 8'hFF, 0, 1, F2,    0, 0, 0, 8'd0, 0, 0)); // 27 s2 latch FF Z=1
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 13'h0803, 0, 0, 0, 8'd7, 0, 0)); // 28 s3
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 13'h0003, 0, 0, 0, 8'd7, 0, 0)); // 29 s4
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 13'h0803, 0, 0, 0, 8'd7, 0, 0)); // 30 s5
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 13'h0003, 0, 0, 0, 8'd7, 0, 0)); // 31 s6
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 13'h0803, 0, 0, 0, 8'd7, 0, 0)); // 32 s7 no END
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, F0,    1, 1, 0, 8'd7, 0, 1)); // 33 wrap, error pulse
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, F1,    0, 1, 0, 8'd7, 0, 0)); // 34 s1 pulse gone
        vecs.push_back(mk(0, 0, 8'h2A, 0, 0, F2,    0, 0, 0, 8'd7, 0, 0)); // 35 s2 latch 2A
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, IMM3,  0, 0, 1, 8'd5, 0, 0)); // 36 s3
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, F0,    1, 1, 0, 8'd5, 0, 0)); // 37 s0

        // Reset state, held across a clock edge
        #2 i_nReset = 1'b0;
        #1 checkAll(100, 13'h0, 0, 0, 0, 8'd0, 0, 0);
        @(negedge i_clk);
        #1 checkAll(101, 13'h0, 0, 0, 0, 8'd0, 0, 0);
        @(negedge i_clk);
        i_nReset = 1'b1;

        foreach (vecs[i]) begin
            i_wait        = vecs[i].stall;
            i_resume      = vecs[i].resume;
            i_instruction = vecs[i].instr;
            i_aluFlagN    = vecs[i].flagN;
            i_aluFlagZ    = vecs[i].flagZ;
            #1 checkAll(i, vecs[i].ctrl, vecs[i].pcOe, vecs[i].ramSel, vecs[i].immOe,
                        vecs[i].imm, vecs[i].halted, vecs[i].seqErr);
            @(negedge i_clk);
        end

        // Stall in fetch step 1, then asynchronous reset mid-stall
        i_wait = 1'b1;
        i_resume = 1'b0;
        i_instruction = 8'h00;
        i_aluFlagN = 1'b0;
        i_aluFlagZ = 1'b0;
        #1 checkAll(200, F1, 0, 1, 0, 8'd5, 0, 0);
        @(negedge i_clk);
        #1 checkAll(201, F1, 0, 1, 0, 8'd5, 0, 0);
        #2 i_nReset = 1'b0;
        #1 checkAll(202, 13'h0, 0, 0, 0, 8'd0, 0, 0);
        @(posedge i_clk);
        #1 checkAll(203, 13'h0, 0, 0, 0, 8'd0, 0, 0);
        @(negedge i_clk);
        i_wait = 1'b0;
        i_nReset = 1'b1;
        #1 checkAll(204, 13'h0, 0, 0, 0, 8'd0, 0, 0);
        @(negedge i_clk);
        #1 checkAll(205, F0, 1, 1, 0, 8'd0, 0, 0);
        @(negedge i_clk);
        #1 checkAll(206, F1, 0, 1, 0, 8'd0, 0, 0);

        // Asynchronous reset while halted
        @(negedge i_clk);
        i_instruction = 8'h01;
        #1 checkAll(207, F2, 0, 0, 0, 8'd0, 0, 0);
        @(negedge i_clk);
        #1 checkAll(208, HLT3, 0, 0, 0, 8'd0, 0, 0);
        @(negedge i_clk);
        #1 checkAll(209, 13'h0, 0, 0, 0, 8'd0, 1, 0);
        #2 i_nReset = 1'b0;
        #1 checkAll(210, 13'h0, 0, 0, 0, 8'd0, 0, 0);
        @(negedge i_clk);
        i_nReset = 1'b1;
        @(negedge i_clk);
        #1 checkAll(211, F0, 1, 1, 0, 8'd0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
